axi3_rd_arbiter: RTL and testbench
==================================

// Module: axi3_rd_arbiter
// PURPOSE
//   Shares one AXI3 read port (the mem_device / axi_ram slave) between N_MASTERS
//   read requesters (e.g. icache, dcache, uncached load path). Round-robin grant,
//   one outstanding burst at a time. The grant is held from the AR handshake
//   through the R beat with rlast. Sits between the cache read masters and
//   mem_device.axi3_rd_if in the testbench and SoC memory path.
// PARAMETERS
//   N_MASTERS   2    number of upstream read masters (>=2)
//   BUS_WIDTH   4    AXI ID width; must match the mem_device BUS_WIDTH
// PORTS
//   clk     in   1                  single clock, all logic on posedge
//   rst     in   1                  synchronous, active-high reset
//   m_rd    intf axi3_rd_if.slave [N_MASTERS]  upstream masters (index 0 = m0)
//   s_rd    intf axi3_rd_if.master            downstream slave (mem_device)
//   grant   out  $clog2(N_MASTERS) currently / last granted master index (debug)
//   busy    out  1                  1 while state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, rr_ptr=0, grant=0, busy=0; s_rd.arvalid=0, s_rd.rready=0;
//     every m_rd[i]: arready=0, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0.
//   - FSM: IDLE -> AR -> R -> IDLE.
//   - IDLE: if any m_rd[i].arvalid, pick the first requester at or after rr_ptr
//     (cyclic). Register grant=i and go to AR next cycle. No outputs asserted.
//   - AR: s_rd.ar* (araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid)
//     mux combinationally from m_rd[grant]. s_rd.arvalid = m_rd[grant].arvalid.
//     m_rd[grant].arready = s_rd.arready; all other arready=0. Handshake -> R.
//   - R: m_rd[grant].{rvalid, rdata, rresp, rlast, rid} = s_rd.*.
//     s_rd.rready = m_rd[grant].rready. Non-granted masters see rvalid=0.
//     Beat with rvalid&rready&rlast -> IDLE, rr_ptr=(grant+1)%N_MASTERS.
//   - Latency: arvalid sampled in IDLE at cycle t gives s_rd.arvalid at t+1.
//     There is exactly one idle bubble cycle after each rlast. The R path adds
//     zero cycles (combinational).
//   - IDs pass through unchanged. Routing uses the grant register, not rid.
//   - Upstream arvalid must be held until arready (AXI rule). The arbiter does
//     not check it. A deasserted arvalid in AR simply stalls in AR.
//   - Simultaneous requests: rr_ptr decides. A master that loses keeps arvalid
//     high and is served at its turn. With N requesters, no master waits more
//     than N-1 bursts.
//   - arlen=0: a single beat with rlast returns to IDLE normally.
//   - Reset mid-burst: immediate return to IDLE with reset values. The in-flight
//     slave burst is abandoned, and the bench must reset the slave too.
//   - Write channel is not handled here. axi3_wr_if is routed separately.
// STRUCTURE
//   - axi_arb_pkg: typedef enum logic[1:0] {ARB_IDLE, ARB_AR, ARB_R} arb_state_t.
//     Also holds the function rr_pick(req, ptr) that returns the index and a
//     valid flag.
//   - Sub-module rr_arbiter #(N) (req vector, update strobe, next_ptr, gnt_idx,
//     gnt_valid): owns the rr_ptr register.
//   - Top holds the FSM, the grant register and the AR/R muxes.
// TESTING
//   1. Reset then idle: all m_rd arready/rvalid=0, s_rd arvalid=0, busy=0
//      for 10 cycles.
//   2. m0 reads araddr=0x100, arlen=3 alone -> s_rd.araddr=0x100 one cycle after
//      request. Four beats with data from memory reach m0 only. m1 rvalid stays 0.
//   3. m0 and m1 assert arvalid in the same cycle after reset -> m0 is served
//      first, m1 next. grant goes 0->1. The next simultaneous pair serves m1 then m0.
//   4. m1 arlen=0 at 0x200 while the slave stalls arready for 5 cycles -> state
//      stays in AR. Single beat with rlast; back in IDLE 1 cycle after.
//   5. m0 holds rready=0 for 3 cycles mid-burst -> s_rd.rready=0 and slave data
//      is held. No beat is lost or duplicated (scoreboard check vs axi_ram).
//   6. rst asserted during beat 2 of an arlen=7 burst -> next cycle
//      state=IDLE, busy=0, all outputs at reset values, rr_ptr=0.

Source files
------------

// File: rtl/axi3_rd_arbiter_pkg.sv
// axi3_rd_arbiter_pkg: shared types, widths and the round-robin pick function for the AXI3 read arbiter.
package axi3_rd_arbiter_pkg;
  localparam int MAX_M = 32;
  localparam int IDX_W = 5;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {ARB_IDLE, ARB_AR, ARB_R} arb_state_t;
  typedef struct packed {
    logic valid;
    logic [IDX_W-1:0] idx;
  } pick_t;
  // Scans from ptr cyclically; descending k lets the closest requester win.
  function automatic pick_t rr_pick(input logic [MAX_M-1:0] req, input logic [IDX_W-1:0] ptr, input int n);
    pick_t p;
    p = '0;
    for (int k = MAX_M - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % n;
      if (k < n && req[j[IDX_W-1:0]]) p = '{valid: 1'b1, idx: j[IDX_W-1:0]};
    end
    return p;
  endfunction
endpackage

// File: rtl/axi3_rd_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin requester pick; owns the rotating priority pointer.
module rr_arbiter import axi3_rd_arbiter_pkg::*; #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         upd_i,
  input  logic [W-1:0] next_ptr_i,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_valid_o
);
  logic [W-1:0] ptr_q, ptr_d;
  pick_t pick;
  assign pick = rr_pick(MAX_M'(req_i), IDX_W'(ptr_q), N);
  assign gnt_idx_o = W'(pick.idx);
  assign gnt_valid_o = pick.valid;
  assign ptr_d = upd_i ? next_ptr_i : ptr_q;
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/axi3_rd_arbiter.sv
// axi3_rd_arbiter: shares one AXI3 read port among N masters, one burst at a time, round-robin.
module axi3_rd_arbiter import axi3_rd_arbiter_pkg::*; #(
  parameter int N_MASTERS = 2,
  parameter int BUS_WIDTH = 4,
  localparam int GW = $clog2(N_MASTERS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_MASTERS-1:0]                  m_arvalid_i,
  output logic [N_MASTERS-1:0]                  m_arready_o,
  input  logic [N_MASTERS-1:0][ADDR_W-1:0]      m_araddr_i,
  input  logic [N_MASTERS-1:0][3:0]             m_arlen_i,
  input  logic [N_MASTERS-1:0][2:0]             m_arsize_i,
  input  logic [N_MASTERS-1:0][1:0]             m_arburst_i,
  input  logic [N_MASTERS-1:0][1:0]             m_arlock_i,
  input  logic [N_MASTERS-1:0][3:0]             m_arcache_i,
  input  logic [N_MASTERS-1:0][2:0]             m_arprot_i,
  input  logic [N_MASTERS-1:0][BUS_WIDTH-1:0]   m_arid_i,
  output logic [N_MASTERS-1:0]                  m_rvalid_o,
  input  logic [N_MASTERS-1:0]                  m_rready_i,
  output logic [N_MASTERS-1:0][DATA_W-1:0]      m_rdata_o,
  output logic [N_MASTERS-1:0][1:0]             m_rresp_o,
  output logic [N_MASTERS-1:0]                  m_rlast_o,
  output logic [N_MASTERS-1:0][BUS_WIDTH-1:0]   m_rid_o,
  output logic                                  s_arvalid_o,
  input  logic                                  s_arready_i,
  output logic [ADDR_W-1:0]                     s_araddr_o,
  output logic [3:0]                            s_arlen_o,
  output logic [2:0]                            s_arsize_o,
  output logic [1:0]                            s_arburst_o,
  output logic [1:0]                            s_arlock_o,
  output logic [3:0]                            s_arcache_o,
  output logic [2:0]                            s_arprot_o,
  output logic [BUS_WIDTH-1:0]                  s_arid_o,
  input  logic                                  s_rvalid_i,
  output logic                                  s_rready_o,
  input  logic [DATA_W-1:0]                     s_rdata_i,
  input  logic [1:0]                            s_rresp_i,
  input  logic                                  s_rlast_i,
  input  logic [BUS_WIDTH-1:0]                  s_rid_i,
  output logic [GW-1:0]                         grant_o,
  output logic                                  busy_o
);
  arb_state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, next_ptr, gnt_idx;
  logic gnt_valid, in_idle, in_ar, in_r, ar_hs, r_last;
  assign in_idle = state_q == ARB_IDLE;
  assign in_ar = state_q == ARB_AR;
  assign in_r = state_q == ARB_R;
  assign s_arvalid_o = in_ar & m_arvalid_i[grant_q];
  assign s_araddr_o = m_araddr_i[grant_q];
  assign s_arlen_o = m_arlen_i[grant_q];
  assign s_arsize_o = m_arsize_i[grant_q];
  assign s_arburst_o = m_arburst_i[grant_q];
  assign s_arlock_o = m_arlock_i[grant_q];
  assign s_arcache_o = m_arcache_i[grant_q];
  assign s_arprot_o = m_arprot_i[grant_q];
  assign s_arid_o = m_arid_i[grant_q];
  assign s_rready_o = in_r & m_rready_i[grant_q];
  assign ar_hs = s_arvalid_o & s_arready_i;
  assign r_last = s_rvalid_i & s_rready_o & s_rlast_i;
  assign next_ptr = (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
  assign grant_o = grant_q;
  assign busy_o = !in_idle;
  rr_arbiter #(.N(N_MASTERS)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (m_arvalid_i),
    .upd_i       (r_last),
    .next_ptr_i  (next_ptr),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );
  always_comb begin
    state_d = (in_idle && gnt_valid) ? ARB_AR : ar_hs ? ARB_R : r_last ? ARB_IDLE : state_q;
    grant_d = (in_idle && gnt_valid) ? gnt_idx : grant_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end
  // Return path is purely combinational; only the granted master ever sees R traffic.
  always_comb begin
    m_arready_o = '0;
    m_rvalid_o = '0;
    m_rlast_o = '0;
    m_rdata_o = '0;
    m_rresp_o = '0;
    m_rid_o = '0;
    m_arready_o[grant_q] = in_ar & s_arready_i;
    m_rvalid_o[grant_q] = in_r & s_rvalid_i;
    m_rlast_o[grant_q] = in_r & s_rlast_i;
    m_rdata_o[grant_q] = in_r ? s_rdata_i : '0;
    m_rresp_o[grant_q] = in_r ? s_rresp_i : '0;
    m_rid_o[grant_q] = in_r ? s_rid_i : '0;
  end
endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb_axi3_rd_arbiter: directed checks of the AXI3 read arbiter against a small behavioural read slave.
module tb_axi3_rd_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] m_arvalid_i, m_arready_o, m_rvalid_o, m_rready_i, m_rlast_o;
  logic [1:0][31:0] m_araddr_i, m_rdata_o;
  logic [1:0][3:0] m_arlen_i, m_arcache_i, m_arid_i, m_rid_o;
  logic [1:0][2:0] m_arsize_i, m_arprot_i;
  logic [1:0][1:0] m_arburst_i, m_arlock_i, m_rresp_o;
  logic s_arvalid_o, s_arready_i, s_rvalid_i, s_rready_o, s_rlast_i, grant_o, busy_o;
  logic [31:0] s_araddr_o, s_rdata_i;
  logic [3:0] s_arlen_o, s_arcache_o, s_arid_o, s_rid_i;
  logic [2:0] s_arsize_o, s_arprot_o;
  logic [1:0] s_arburst_o, s_arlock_o, s_rresp_i;
  axi3_rd_arbiter #(.N_MASTERS(2), .BUS_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid_i(m_arvalid_i), .m_arready_o(m_arready_o), .m_araddr_i(m_araddr_i),
    .m_arlen_i(m_arlen_i), .m_arsize_i(m_arsize_i), .m_arburst_i(m_arburst_i),
    .m_arlock_i(m_arlock_i), .m_arcache_i(m_arcache_i), .m_arprot_i(m_arprot_i),
    .m_arid_i(m_arid_i), .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i),
    .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o), .m_rlast_o(m_rlast_o), .m_rid_o(m_rid_o),
    .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i), .s_araddr_o(s_araddr_o),
    .s_arlen_o(s_arlen_o), .s_arsize_o(s_arsize_o), .s_arburst_o(s_arburst_o),
    .s_arlock_o(s_arlock_o), .s_arcache_o(s_arcache_o), .s_arprot_o(s_arprot_o),
    .s_arid_o(s_arid_o), .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
    .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rlast_i(s_rlast_i), .s_rid_i(s_rid_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );
  int n_chk = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] dval(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  // Read slave: one burst at a time, arready held off for ar_stall cycles of arvalid.
  int ar_stall = 0;
  int wait_cnt;
  logic sl_busy;
  logic [31:0] sl_addr;
  logic [3:0] sl_len, sl_beat, sl_id;
  assign s_arready_i = !sl_busy && wait_cnt >= ar_stall;
  assign s_rvalid_i = sl_busy;
  assign s_rdata_i = sl_busy ? dval(sl_addr + {26'd0, sl_beat, 2'b00}) : '0;
  assign s_rlast_i = sl_busy && sl_beat == sl_len;
  assign s_rid_i = sl_id;
  assign s_rresp_i = 2'b00;
  always @(posedge clk) begin
    if (rst) begin
      sl_busy <= 1'b0;
      sl_beat <= '0;
      sl_len <= '0;
      sl_id <= '0;
      sl_addr <= '0;
      wait_cnt <= 0;
    end else begin
      if (s_arvalid_o && s_arready_i) begin
        sl_busy <= 1'b1;
        sl_addr <= s_araddr_o;
        sl_len <= s_arlen_o;
        sl_id <= s_arid_o;
        sl_beat <= '0;
        wait_cnt <= 0;
      end else if (s_arvalid_o) wait_cnt <= wait_cnt + 1;
      if (s_rvalid_i && s_rready_o) begin
        if (s_rlast_i) sl_busy <= 1'b0;
        else sl_beat <= sl_beat + 4'd1;
      end
    end
  end
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  int order[$];
  int rv1_cnt = 0;
  always @(posedge clk) begin
    if (m_rvalid_o[0] && m_rready_i[0]) rq0.push_back(m_rdata_o[0]);
    if (m_rvalid_o[1] && m_rready_i[1]) rq1.push_back(m_rdata_o[1]);
    if (m_rvalid_o[1]) rv1_cnt++;
    if (s_arvalid_o && s_arready_i) order.push_back(int'(grant_o));
  end
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic issue(input int m, input logic [31:0] a, input logic [3:0] l, input logic [3:0] id);
    int k;
    m_araddr_i[m] = a;
    m_arlen_i[m] = l;
    m_arid_i[m] = id;
    m_arvalid_i[m] = 1'b1;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (m_arready_o[m]) break;
    end
    check($sformatf("ar_hs_m%0d", m), 64'(k < 60), 64'd1);
    @(posedge clk);
    #1 m_arvalid_i[m] = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    check("idle_wait", 64'(k < budget), 64'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int b0, b1, ob, sn;
    m_arvalid_i = '0;
    m_araddr_i = '0;
    m_arlen_i = '0;
    m_arid_i = '0;
    m_arcache_i = '0;
    m_arprot_i = '0;
    m_arlock_i = '0;
    m_arsize_i = {3'd2, 3'd2};
    m_arburst_i = {2'd1, 2'd1};
    m_rready_i = 2'b11;
    do_reset();
    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_idle", {m_arready_o, m_rvalid_o, s_arvalid_o, s_rready_o, busy_o}, 0);
    end
    check("t1_grant", grant_o, 0);
    // m0 alone, arlen=3
    b0 = rq0.size();
    sn = rv1_cnt;
    m_araddr_i[0] = 32'h100;
    m_arlen_i[0] = 4'd3;
    m_arid_i[0] = 4'd5;
    m_arvalid_i[0] = 1'b1;
    @(negedge clk);
    check("t2_s_arvalid", s_arvalid_o, 1);
    check("t2_s_araddr", s_araddr_o, 32'h100);
    check("t2_s_arlen", s_arlen_o, 3);
    check("t2_s_arid", s_arid_o, 5);
    check("t2_arready", m_arready_o, 2'b01);
    @(posedge clk);
    #1 m_arvalid_i[0] = 1'b0;
    @(negedge clk);
    check("t2_rid", m_rid_o[0], 5);
    wait_idle(20);
    check("t2_beats", rq0.size() - b0, 4);
    for (int k = 0; k < 4; k++) check($sformatf("t2_data%0d", k), rq0[b0+k], dval(32'h100 + 32'(4 * k)));
    check("t2_m1_rvalid", rv1_cnt - sn, 0);
    // Simultaneous requests after reset
    do_reset();
    ob = order.size();
    b1 = rq1.size();
    fork
      issue(0, 32'h300, 4'd1, 4'd1);
      issue(1, 32'h400, 4'd1, 4'd2);
    join
    wait_idle(40);
    check("t3_norder", order.size() - ob, 2);
    check("t3_first", order[ob], 0);
    check("t3_second", order[ob+1], 1);
    check("t3_m1_d0", rq1[b1], dval(32'h400));
    check("t3_m1_d1", rq1[b1+1], dval(32'h404));
    issue(0, 32'h340, 4'd0, 4'd3);
    wait_idle(20);
    ob = order.size();
    fork
      issue(0, 32'h380, 4'd0, 4'd1);
      issue(1, 32'h480, 4'd0, 4'd2);
    join
    wait_idle(40);
    check("t3_pair2_first", order[ob], 1);
    check("t3_pair2_second", order[ob+1], 0);
    // m1 arlen=0 with arready stalled 5 cycles
    ar_stall = 5;
    m_araddr_i[1] = 32'h200;
    m_arlen_i[1] = 4'd0;
    m_arid_i[1] = 4'd7;
    m_arvalid_i[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall", {busy_o, s_arvalid_o, m_arready_o}, 4'b1100);
    end
    check("t4_addr", s_araddr_o, 32'h200);
    @(negedge clk);
    check("t4_arready", m_arready_o, 2'b10);
    @(posedge clk);
    #1 m_arvalid_i[1] = 1'b0;
    ar_stall = 0;
    @(negedge clk);
    check("t4_rvalid", m_rvalid_o, 2'b10);
    check("t4_rlast", m_rlast_o, 2'b10);
    check("t4_rdata", m_rdata_o[1], dval(32'h200));
    check("t4_rid", m_rid_o[1], 7);
    @(negedge clk);
    check("t4_idle", busy_o, 0);
    // m0 backpressure mid-burst
    b0 = rq0.size();
    issue(0, 32'h500, 4'd3, 4'd4);
    @(negedge clk);
    @(negedge clk);
    m_rready_i[0] = 1'b0;
    #1 check("t5_s_rready", s_rready_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold", {s_rready_o, m_rvalid_o[0], m_rdata_o[0]}, {1'b0, 1'b1, dval(32'h504)});
    end
    m_rready_i[0] = 1'b1;
    wait_idle(20);
    check("t5_beats", rq0.size() - b0, 4);
    for (int k = 0; k < 4; k++) check($sformatf("t5_data%0d", k), rq0[b0+k], dval(32'h500 + 32'(4 * k)));
    // Reset during beat 2 of an arlen=7 burst from m1
    issue(1, 32'h600, 4'd7, 4'd9);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t6_beat2", m_rdata_o[1], dval(32'h608));
    rst = 1'b1;
    @(negedge clk);
    check("t6_reset_outs", {busy_o, grant_o, m_rvalid_o, m_arready_o, m_rlast_o, s_arvalid_o, s_rready_o}, 0);
    check("t6_reset_rdata", m_rdata_o, 0);
    rst = 1'b0;
    ob = order.size();
    fork
      issue(0, 32'h700, 4'd0, 4'd1);
      issue(1, 32'h780, 4'd0, 4'd2);
    join
    wait_idle(40);
    check("t6_ptr_first", order[ob], 0);
    check("t6_ptr_second", order[ob+1], 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
